// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed host byte stream into 32-bit instruction words
// and writes them to instruction memory while holding the core in reset.
module imem_loader #(
    parameter int          DEPTH = 128,
    parameter logic [31:0] BASE  = 32'h0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ByteValid,
    input  logic [7:0]  ByteData,
    output logic        ByteReady,
    output logic        IMemWrite,
    output logic [31:0] IMemAddress,
    output logic [31:0] IMemWriteData,
    output logic        CoreRst,
    output logic        LoadDone,
    output logic        LoadError
);
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR} state_t;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    state_t      state, state_nxt;
    logic [15:0] n, k, n_new;
    logic [1:0]  cnt;
    logic [31:0] word, addr;
    logic        xfer, last;
    assign xfer          = ByteValid && ByteReady;
    assign n_new         = {n[15:8], ByteData};
    assign last          = ({1'b0, k} + 17'd1) == {1'b0, n};
    assign IMemAddress   = addr;
    assign IMemWriteData = word;
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) state <= LEN_HI;
        else     state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            LEN_HI:  state_nxt = xfer ? LEN_LO : LEN_HI;
            LEN_LO:  if (xfer) state_nxt = (n_new == 16'd0) ? DONE :
                                           ({1'b0, n_new} > DEPTH_W) ? ERROR : DATA;
            DATA:    state_nxt = (xfer && cnt == 2'd3) ? WRITE : DATA;
            WRITE:   state_nxt = last ? DONE : DATA;
            default: state_nxt = state;
        endcase
    end
    always_comb begin
        ByteReady = !Rst && (state == LEN_HI || state == LEN_LO || state == DATA);
        IMemWrite = state == WRITE;
    end
    // Address only advances when another word follows, so it never passes the last slot.
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            n         <= '0;
            k         <= '0;
            cnt       <= '0;
            word      <= '0;
            addr      <= BASE;
            CoreRst   <= 1'b1;
            LoadDone  <= 1'b0;
            LoadError <= 1'b0;
        end else begin
            if (state == LEN_HI && xfer) n[15:8] <= ByteData;
            if (state == LEN_LO && xfer) n[7:0] <= ByteData;
            if (state == DATA && xfer) begin
                cnt  <= cnt + 2'd1;
                word <= {word[23:0], ByteData};
            end
            if (state == WRITE && !last) begin
                k    <= k + 16'd1;
                addr <= addr + 32'd4;
            end
            CoreRst   <= state_nxt != DONE;
            LoadDone  <= state_nxt == DONE;
            LoadError <= state_nxt == ERROR;
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams with a write scoreboard; a monitor pops expected
// (address, data) pairs whenever the loader strobes IMemWrite.
module tb_imem_loader;
    logic        Clk = 1'b0, Rst = 1'b1, ByteValid = 1'b0;
    logic [7:0]  ByteData = '0;
    logic        ByteReady, IMemWrite, CoreRst, LoadDone, LoadError;
    logic [31:0] IMemAddress, IMemWriteData;
    int          n_cmp = 0, n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic        prev_wr = 1'b0;

    imem_loader #(.DEPTH(128), .BASE(32'h0)) dut (
        .Clk(Clk), .Rst(Rst), .ByteValid(ByteValid), .ByteData(ByteData),
        .ByteReady(ByteReady), .IMemWrite(IMemWrite), .IMemAddress(IMemAddress),
        .IMemWriteData(IMemWriteData), .CoreRst(CoreRst), .LoadDone(LoadDone),
        .LoadError(LoadError)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rst && IMemWrite) begin
            check("wr_pulse_width", 32'(prev_wr), 32'd0);
            check("wr_addr_bound", 32'(IMemAddress <= 32'h1FC), 32'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", IMemAddress, IMemWriteData);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", IMemAddress, mon_e[63:32]);
                check("wr_data", IMemWriteData, mon_e[31:0]);
            end
        end
        prev_wr = IMemWrite && !Rst;
    end

    task automatic send_byte(input logic [7:0] b);
        int   t;
        logic ok;
        t = 0;
        ok = 1'b0;
        ByteValid = 1'b1;
        ByteData  = b;
        while (!ok && t < 20) begin
            @(negedge Clk);
            ok = ByteReady;
            @(posedge Clk);
            #1;
            t++;
        end
        ByteValid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: byte %h got ready 0 expected 1", b);
        end
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        Rst = 1'b1;
        ByteValid = 1'b0;
        idle(2);
        Rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    initial begin
        logic [31:0] w;
        @(negedge Clk);
        check("rst_ready", 32'(ByteReady), 32'd0);
        check("rst_write", 32'(IMemWrite), 32'd0);
        check("rst_addr", IMemAddress, 32'h0);
        check("rst_data", IMemWriteData, 32'h0);
        check("rst_corerst", 32'(CoreRst), 32'd1);
        check("rst_done", 32'(LoadDone), 32'd0);
        check("rst_error", 32'(LoadError), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("post_rst_ready", 32'(ByteReady), 32'd1);
        check("post_rst_corerst", 32'(CoreRst), 32'd1);
        idle(1);

        // two-word load, valid held high
        exp_q.push_back({32'h0, 32'h20080005});
        exp_q.push_back({32'h4, 32'h01095020});
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h20080005);
        send_word(32'h01095020);
        @(negedge Clk);
        check("write_cyc_corerst", 32'(CoreRst), 32'd1);
        check("write_cyc_done", 32'(LoadDone), 32'd0);
        @(negedge Clk);
        check("done_corerst", 32'(CoreRst), 32'd0);
        check("done_loaddone", 32'(LoadDone), 32'd1);
        check("done_ready", 32'(ByteReady), 32'd0);
        idle(2);

        // empty program
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        @(negedge Clk);
        @(negedge Clk);
        check("empty_done", 32'(LoadDone), 32'd1);
        check("empty_corerst", 32'(CoreRst), 32'd0);
        idle(2);

        // oversize count
        do_reset();
        send_byte(8'h00); send_byte(8'h81);
        @(negedge Clk);
        check("err_flag", 32'(LoadError), 32'd1);
        check("err_corerst", 32'(CoreRst), 32'd1);
        check("err_ready", 32'(ByteReady), 32'd0);
        check("err_done", 32'(LoadDone), 32'd0);
        ByteValid = 1'b1;
        ByteData  = 8'h55;
        idle(4);
        ByteValid = 1'b0;
        @(negedge Clk);
        check("err_sticky", 32'(LoadError), 32'd1);
        check("err_ready_sticky", 32'(ByteReady), 32'd0);
        idle(1);

        // one word with host stalls every other cycle
        do_reset();
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        send_byte(8'h00); idle(1);
        send_byte(8'h01); idle(1);
        send_byte(8'hDE); idle(1);
        send_byte(8'hAD); idle(1);
        send_byte(8'hBE); idle(1);
        send_byte(8'hEF);
        idle(2);
        @(negedge Clk);
        check("stall_done", 32'(LoadDone), 32'd1);
        idle(1);

        // reset mid-word, then a fresh load
        do_reset();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        Rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(ByteReady), 32'd0);
        check("async_rst_word", IMemWriteData, 32'h0);
        check("async_rst_corerst", 32'(CoreRst), 32'd1);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        exp_q.push_back({32'h0, 32'h11223344});
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h11223344);
        @(negedge Clk);
        @(negedge Clk);
        check("midrst_done", 32'(LoadDone), 32'd1);
        idle(1);

        // full memory
        do_reset();
        send_byte(8'h00); send_byte(8'h80);
        for (int i = 0; i < 128; i++) begin
            w = {8'(i), 8'hA5, ~8'(i), 8'h3C};
            exp_q.push_back({32'(i * 4), w});
            send_word(w);
        end
        @(negedge Clk);
        check("full_last_addr", IMemAddress, 32'h1FC);
        @(negedge Clk);
        check("full_done", 32'(LoadDone), 32'd1);
        check("full_error", 32'(LoadError), 32'd0);
        idle(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  128  instruction-memory capacity in 32-bit words
  BASE   0    byte address of the first word written
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning (clock and reset first).
  Clk            in   1   single clock, rising edge
  Rst            in   1   reset, asynchronous, active-high
  ByteValid      in   1   host byte offered
  ByteData       in   8   host byte
  ByteReady      out  1   loader accepts byte this cycle
  IMemWrite      out  1   instruction-memory write strobe, one cycle per word
  IMemAddress    out  32  byte address of the word being written
  IMemWriteData  out  32  assembled instruction word
  CoreRst        out  1   holds the pipeline in reset while loading
  LoadDone       out  1   program loaded, core released
  LoadError      out  1   word count exceeded DEPTH
REQ-003 The block SHALL have exactly one clock (Clk); Rst SHALL be asynchronous and active-high.

Function
REQ-004 A byte SHALL transfer only on a rising Clk edge where ByteValid=1 and ByteReady=1; ByteData SHALL be ignored otherwise.
REQ-005 Stream format SHALL be: 2-byte word count N (MSB first), then N words of 4 bytes each, MSB first.
REQ-006 States SHALL be LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
REQ-007 LEN_HI: ByteReady=1; on transfer, latch N[15:8] and go to LEN_LO.
REQ-008 LEN_LO: ByteReady=1; on transfer, latch N[7:0] and go to DATA if 0<N<=DEPTH; to DONE if N=0; to ERROR if N>DEPTH.
REQ-009 DATA: ByteReady=1; a 2-bit byte counter SHALL shift each byte into the word, MSB first; on the 4th transfer go to WRITE.
REQ-010 WRITE: ByteReady=0; IMemWrite=1 for exactly one cycle, with IMemAddress=BASE+4*k, where k is the 0-based word index, and IMemWriteData=the assembled word.
REQ-011 After WRITE, k SHALL increment; the FSM SHALL go to DONE if k+1=N, otherwise to DATA.
REQ-012 Per-word latency SHALL be 5 cycles minimum: 4 byte cycles plus 1 write cycle. Host stalls (ByteValid=0) SHALL add cycles without losing state.
REQ-013 DONE: ByteReady=0, CoreRst=0, LoadDone=1; the FSM SHALL stay in DONE until Rst.
REQ-014 ERROR: ByteReady=0, CoreRst=1, LoadError=1, IMemWrite=0; the FSM SHALL stay in ERROR until Rst.
REQ-015 CoreRst SHALL be 1 in every state except DONE; it SHALL deassert on the first cycle of DONE and be registered, with no glitch.
REQ-016 IMemWrite SHALL never assert outside WRITE; IMemAddress SHALL never exceed BASE+4*(DEPTH-1).
REQ-017 All outputs SHALL be driven from registers or be a decode of the FSM state only.
REQ-018 The word counter SHALL be 16 bits wide; the comparison with N SHALL be unsigned with no wrap-around.

Reset
REQ-019 Rst=1 SHALL force, asynchronously, state=LEN_HI, k=0, byte counter=0, N=0, word register=0.
REQ-020 Reset values SHALL be: ByteReady=1 after Rst deasserts (0 while Rst=1), IMemWrite=0, IMemAddress=BASE, IMemWriteData=0, CoreRst=1, LoadDone=0, LoadError=0.
REQ-021 Rst asserted mid-load SHALL abandon the partial word with no write, and loading SHALL restart from LEN_HI.

Verification
REQ-022 Stream 00 02 | 20 08 00 05 | 01 09 50 20 with ByteValid held high -> writes (0x0,0x20080005) and (0x4,0x01095020), each IMemWrite 1 cycle wide; CoreRst falls and LoadDone rises the cycle after the 2nd write.
REQ-023 Stream 00 00 -> no IMemWrite; LoadDone=1 and CoreRst=0 two cycles after the second byte is accepted.
REQ-024 With DEPTH=128, stream 00 81 -> LoadError=1, CoreRst stays 1, ByteReady=0, and later bytes are ignored.
REQ-025 N=1 with ByteValid toggling 1/0 every cycle -> the word assembles correctly and exactly one write occurs at address BASE.
REQ-026 Rst pulsed after 2 of 4 data bytes, then a full 1-word stream -> only the new word is written, at address BASE, and no partial word is written.
REQ-027 Load DEPTH=128 words -> the last write is at address 0x1FC, followed by DONE, with no write beyond it.
